axi_rr_arbiter: RTL and testbench
=================================

AXI_RR_ARBITER -- requirements
Module: axi_rr_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADD_SIZE 32 address width; DATA_SIZE 32 data width; LEN_SIZE 4 burst length width; S_SIZE 3 size width; BURST_SIZE 2 burst type width.
REQ-002 ACLK  in  1  single clock; all state changes on rising edge.
REQ-003 ARESET  in  1  asynchronous, active-high reset.
REQ-004 Mx_AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  ADD_SIZE/LEN_SIZE/S_SIZE/BURST_SIZE/1  master x (x=0,1) write address.
REQ-005 Mx_AWREADY  out  1  write address ready to master x.
REQ-006 Mx_WDATA/WLAST/WVALID  in  DATA_SIZE/1/1  master x write data.
REQ-007 Mx_WREADY  out  1  write data ready to master x.
REQ-008 Mx_ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  as AW  master x read address.
REQ-009 Mx_ARREADY  out  1  read address ready to master x.
REQ-010 Mx_RDATA/RLAST/RVALID  out  DATA_SIZE/1/1  read data to master x.
REQ-011 Mx_RREADY  in  1  read data ready from master x.
REQ-012 S_AW*/S_W*/S_AR* (VALID and payload)  out  as above  shared slave request channels; S_AWREADY, S_WREADY, S_ARREADY in.
REQ-013 S_RDATA/S_RLAST/S_RVALID  in; S_RREADY out  shared slave read data channel.
REQ-014 WGRANT, RGRANT  out  2  one-hot current write/read owner; 00 when idle.
REQ-015 WLAST_ERR, RLAST_ERR  out  1  one-cycle protocol error pulses.

Function
REQ-016 The write path and the read path each run an independent FSM with states IDLE, ADDR, and DATA. Reads and writes proceed concurrently without interaction.
REQ-017 IDLE: if any Mx_AxVALID=1, the winner is registered into the GRANT register and the FSM moves to ADDR on the next edge. This gives exactly one bubble cycle, so S_AxVALID first rises in the cycle after the request is seen.
REQ-018 Round robin: one last-winner bit per path. When both masters request, the master that did not win last is granted. A single requester is always granted.
REQ-019 ADDR: S_Ax* = granted master's Ax*, and granted Mx_AxREADY = S_AxREADY. On S_AxVALID&&S_AxREADY, AxLEN is latched into a beat counter limit, the beat count clears to 0, and the FSM moves to DATA.
REQ-020 DATA (write): S_W* forwards the granted master's W*, and granted Mx_WREADY = S_WREADY. S_WLAST is driven by the arbiter as (count==latched AWLEN), not by the master.
REQ-021 DATA (read): granted Mx_R* = S_R*, and S_RREADY = granted Mx_RREADY. The non-granted Mx_RVALID is 0.
REQ-022 Each handshaked beat increments count. The beat with count==latched len (i.e. len+1 beats total) ends the burst: FSM goes to IDLE, GRANT clears to 00, and last-winner updates to the finishing master.
REQ-023 WLAST_ERR pulses for 1 cycle on any W handshake where the master's WLAST != (count==len). The burst still terminates on count.
REQ-024 RLAST_ERR pulses for 1 cycle on any R handshake where S_RLAST != (count==len). The burst still terminates on count.
REQ-025 The non-granted master always sees AxREADY=0 and WREADY=0; its VALID is ignored and its request is held pending.
REQ-026 Outside ADDR, S_AxVALID=0 and S_Ax payload=0. Outside write DATA, S_WVALID=0, S_WLAST=0, and S_WDATA=0. Outside read DATA, S_RREADY=0.
REQ-027 A request arriving while a path is busy is serviced only after the current burst returns to IDLE. There is no preemption.
REQ-028 AxLEN=0 gives a single-beat burst. AxLEN=2^LEN_SIZE-1 gives 2^LEN_SIZE beats, and the counter SHALL NOT wrap within a burst.

Reset
REQ-029 ARESET=1 asynchronously forces both FSMs to IDLE, GRANT=00, count=0, and last-winner=1 (so M0 wins the first tie). All outputs go to 0, including every READY/VALID, both ERR outputs, and all payloads.
REQ-030 Reset asserted mid-burst abandons the burst immediately. No completion beat is issued, and operation resumes from IDLE on the first edge after deassertion.

Verification
REQ-031 Both masters assert AWVALID in the same cycle after reset -> WGRANT=01; M0 burst AWLEN=3 completes 4 beats with S_WLAST on beat 4; then WGRANT=10 for M1.
REQ-032 M1 issues ARLEN=0 while M0 issues a write with AWLEN=7 -> both proceed concurrently; RGRANT=10 completes 1 beat; WGRANT=01 completes 8 beats.
REQ-033 M0 drives WLAST on beat 2 of an AWLEN=3 burst -> WLAST_ERR=1 for that cycle; burst still ends after beat 4.
REQ-034 The slave withholds S_RLAST on the final beat of an ARLEN=2 burst -> RLAST_ERR=1 on beat 3; RGRANT returns to 00.
REQ-035 ARESET pulsed during beat 2 of a write -> all outputs 0 asynchronously; after release, a new M1 request is granted with WGRANT=10 after one cycle.
REQ-036 M0 requests continuously and M1 requests once -> grants alternate M0, M1, M0. M1 is never starved for more than one burst.

Source files
------------

// File: rtl/axi_rr_arbiter.sv
// Two-master to one-slave AXI arbiter with independent round-robin write and read paths.
// Each path grants one master per burst and counts beats so the burst ends on the latched length.
`timescale 1ns/1ps
module axi_rr_arbiter #(
  parameter int ADD_SIZE   = 32,
  parameter int DATA_SIZE  = 32,
  parameter int LEN_SIZE   = 4,
  parameter int S_SIZE     = 3,
  parameter int BURST_SIZE = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // master 0
  input  logic [ADD_SIZE-1:0]   M0_AWADDR,
  input  logic [LEN_SIZE-1:0]   M0_AWLEN,
  input  logic [S_SIZE-1:0]     M0_AWSIZE,
  input  logic [BURST_SIZE-1:0] M0_AWBURST,
  input  logic                  M0_AWVALID,
  output logic                  M0_AWREADY,
  input  logic [DATA_SIZE-1:0]  M0_WDATA,
  input  logic                  M0_WLAST,
  input  logic                  M0_WVALID,
  output logic                  M0_WREADY,
  input  logic [ADD_SIZE-1:0]   M0_ARADDR,
  input  logic [LEN_SIZE-1:0]   M0_ARLEN,
  input  logic [S_SIZE-1:0]     M0_ARSIZE,
  input  logic [BURST_SIZE-1:0] M0_ARBURST,
  input  logic                  M0_ARVALID,
  output logic                  M0_ARREADY,
  output logic [DATA_SIZE-1:0]  M0_RDATA,
  output logic                  M0_RLAST,
  output logic                  M0_RVALID,
  input  logic                  M0_RREADY,
  // master 1
  input  logic [ADD_SIZE-1:0]   M1_AWADDR,
  input  logic [LEN_SIZE-1:0]   M1_AWLEN,
  input  logic [S_SIZE-1:0]     M1_AWSIZE,
  input  logic [BURST_SIZE-1:0] M1_AWBURST,
  input  logic                  M1_AWVALID,
  output logic                  M1_AWREADY,
  input  logic [DATA_SIZE-1:0]  M1_WDATA,
  input  logic                  M1_WLAST,
  input  logic                  M1_WVALID,
  output logic                  M1_WREADY,
  input  logic [ADD_SIZE-1:0]   M1_ARADDR,
  input  logic [LEN_SIZE-1:0]   M1_ARLEN,
  input  logic [S_SIZE-1:0]     M1_ARSIZE,
  input  logic [BURST_SIZE-1:0] M1_ARBURST,
  input  logic                  M1_ARVALID,
  output logic                  M1_ARREADY,
  output logic [DATA_SIZE-1:0]  M1_RDATA,
  output logic                  M1_RLAST,
  output logic                  M1_RVALID,
  input  logic                  M1_RREADY,
  // shared slave
  output logic [ADD_SIZE-1:0]   S_AWADDR,
  output logic [LEN_SIZE-1:0]   S_AWLEN,
  output logic [S_SIZE-1:0]     S_AWSIZE,
  output logic [BURST_SIZE-1:0] S_AWBURST,
  output logic                  S_AWVALID,
  input  logic                  S_AWREADY,
  output logic [DATA_SIZE-1:0]  S_WDATA,
  output logic                  S_WLAST,
  output logic                  S_WVALID,
  input  logic                  S_WREADY,
  output logic [ADD_SIZE-1:0]   S_ARADDR,
  output logic [LEN_SIZE-1:0]   S_ARLEN,
  output logic [S_SIZE-1:0]     S_ARSIZE,
  output logic [BURST_SIZE-1:0] S_ARBURST,
  output logic                  S_ARVALID,
  input  logic                  S_ARREADY,
  input  logic [DATA_SIZE-1:0]  S_RDATA,
  input  logic                  S_RLAST,
  input  logic                  S_RVALID,
  output logic                  S_RREADY,
  // status
  output logic [1:0]            WGRANT,
  output logic [1:0]            RGRANT,
  output logic                  WLAST_ERR,
  output logic                  RLAST_ERR
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]          r_w_state, r_r_state;
  logic [1:0]          r_wgrant,  r_rgrant;
  logic                r_w_last,  r_r_last;   // 1 = master 1 finished the previous burst
  logic [LEN_SIZE-1:0] r_w_cnt,   r_r_cnt;
  logic [LEN_SIZE-1:0] r_w_len,   r_r_len;

  logic [1:0] w_w_pick, w_r_pick;
  logic       w_aw_phase, w_w_phase, w_ar_phase, w_r_phase;
  logic       w_w_sel1, w_r_sel1;
  logic       w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic       w_w_is_last, w_r_is_last;
  logic       w_r_to0, w_r_to1;

  // Round-robin pick: on a tie the master that did not finish last wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_w_pick = 2'b01;
    if (M0_AWVALID && M1_AWVALID) w_w_pick = r_w_last ? 2'b01 : 2'b10;
    else if (M1_AWVALID)          w_w_pick = 2'b10;
    w_r_pick = 2'b01;
    if (M0_ARVALID && M1_ARVALID) w_r_pick = r_r_last ? 2'b01 : 2'b10;
    else if (M1_ARVALID)          w_r_pick = 2'b10;
  end

  assign w_aw_phase  = (r_w_state == ST_ADDR);
  assign w_w_phase   = (r_w_state == ST_DATA);
  assign w_ar_phase  = (r_r_state == ST_ADDR);
  assign w_r_phase   = (r_r_state == ST_DATA);
  assign w_w_sel1    = r_wgrant[1];
  assign w_r_sel1    = r_rgrant[1];
  assign w_w_is_last = (r_w_cnt == r_w_len);
  assign w_r_is_last = (r_r_cnt == r_r_len);

  // Write address and data toward the slave; everything is zero outside its phase.
  assign S_AWVALID  = w_aw_phase & (w_w_sel1 ? M1_AWVALID : M0_AWVALID);
  assign S_AWADDR   = w_aw_phase ? (w_w_sel1 ? M1_AWADDR  : M0_AWADDR)  : '0;
  assign S_AWLEN    = w_aw_phase ? (w_w_sel1 ? M1_AWLEN   : M0_AWLEN)   : '0;
  assign S_AWSIZE   = w_aw_phase ? (w_w_sel1 ? M1_AWSIZE  : M0_AWSIZE)  : '0;
  assign S_AWBURST  = w_aw_phase ? (w_w_sel1 ? M1_AWBURST : M0_AWBURST) : '0;
  assign M0_AWREADY = w_aw_phase & r_wgrant[0] & S_AWREADY;
  assign M1_AWREADY = w_aw_phase & r_wgrant[1] & S_AWREADY;
  assign S_WVALID   = w_w_phase & (w_w_sel1 ? M1_WVALID : M0_WVALID);
  assign S_WDATA    = w_w_phase ? (w_w_sel1 ? M1_WDATA : M0_WDATA) : '0;
  assign S_WLAST    = w_w_phase & w_w_is_last;
  assign M0_WREADY  = w_w_phase & r_wgrant[0] & S_WREADY;
  assign M1_WREADY  = w_w_phase & r_wgrant[1] & S_WREADY;
  assign w_aw_hs    = S_AWVALID & S_AWREADY;
  assign w_w_hs     = S_WVALID & S_WREADY;
  assign WLAST_ERR  = w_w_hs & ((w_w_sel1 ? M1_WLAST : M0_WLAST) != w_w_is_last);

  // Read address toward the slave, read data back to the granted master only.
  assign S_ARVALID  = w_ar_phase & (w_r_sel1 ? M1_ARVALID : M0_ARVALID);
  assign S_ARADDR   = w_ar_phase ? (w_r_sel1 ? M1_ARADDR  : M0_ARADDR)  : '0;
  assign S_ARLEN    = w_ar_phase ? (w_r_sel1 ? M1_ARLEN   : M0_ARLEN)   : '0;
  assign S_ARSIZE   = w_ar_phase ? (w_r_sel1 ? M1_ARSIZE  : M0_ARSIZE)  : '0;
  assign S_ARBURST  = w_ar_phase ? (w_r_sel1 ? M1_ARBURST : M0_ARBURST) : '0;
  assign M0_ARREADY = w_ar_phase & r_rgrant[0] & S_ARREADY;
  assign M1_ARREADY = w_ar_phase & r_rgrant[1] & S_ARREADY;
  assign w_r_to0    = w_r_phase & r_rgrant[0];
  assign w_r_to1    = w_r_phase & r_rgrant[1];
  assign S_RREADY   = w_r_phase & (w_r_sel1 ? M1_RREADY : M0_RREADY);
  assign M0_RVALID  = w_r_to0 & S_RVALID;
  assign M0_RLAST   = w_r_to0 & S_RLAST;
  assign M0_RDATA   = w_r_to0 ? S_RDATA : '0;
  assign M1_RVALID  = w_r_to1 & S_RVALID;
  assign M1_RLAST   = w_r_to1 & S_RLAST;
  assign M1_RDATA   = w_r_to1 ? S_RDATA : '0;
  assign w_ar_hs    = S_ARVALID & S_ARREADY;
  assign w_r_hs     = S_RVALID & S_RREADY;
  assign RLAST_ERR  = w_r_hs & (S_RLAST != w_r_is_last);

  assign WGRANT = r_wgrant;
  assign RGRANT = r_rgrant;

  always_ff @(posedge ACLK or posedge ARESET) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (ARESET) begin
      r_w_state <= ST_IDLE;
      r_wgrant  <= '0;
      r_w_last  <= 1'b1;
      r_w_cnt   <= '0;
      r_w_len   <= '0;
    end else begin
      case (r_w_state)
        ST_IDLE: if (M0_AWVALID || M1_AWVALID) begin
          r_wgrant  <= w_w_pick;
          r_w_state <= ST_ADDR;
        end
        ST_ADDR: if (w_aw_hs) begin
          r_w_len   <= w_w_sel1 ? M1_AWLEN : M0_AWLEN;
          r_w_cnt   <= '0;
          r_w_state <= ST_DATA;
        end
        ST_DATA: if (w_w_hs) begin
          if (w_w_is_last) begin
            r_w_state <= ST_IDLE;
            r_wgrant  <= '0;
            r_w_last  <= r_wgrant[1];
          end else begin
            r_w_cnt <= r_w_cnt + 1'b1;
          end
        end
        default: begin
          r_w_state <= ST_IDLE;
          r_wgrant  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_r_state <= ST_IDLE;
      r_rgrant  <= '0;
      r_r_last  <= 1'b1;
      r_r_cnt   <= '0;
      r_r_len   <= '0;
    end else begin
      case (r_r_state)
        ST_IDLE: if (M0_ARVALID || M1_ARVALID) begin
          r_rgrant  <= w_r_pick;
          r_r_state <= ST_ADDR;
        end
        ST_ADDR: if (w_ar_hs) begin
          r_r_len   <= w_r_sel1 ? M1_ARLEN : M0_ARLEN;
          r_r_cnt   <= '0;
          r_r_state <= ST_DATA;
        end
        ST_DATA: if (w_r_hs) begin
          if (w_r_is_last) begin
            r_r_state <= ST_IDLE;
            r_rgrant  <= '0;
            r_r_last  <= r_rgrant[1];
          end else begin
            r_r_cnt <= r_r_cnt + 1'b1;
          end
        end
        default: begin
          r_r_state <= ST_IDLE;
          r_rgrant  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: arbitration, burst counting, LAST errors and reset.
`timescale 1ns/1ps
module tb_axi_rr_arbiter;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [31:0] M0_AWADDR, M1_AWADDR, M0_ARADDR, M1_ARADDR;
  logic [3:0]  M0_AWLEN, M1_AWLEN, M0_ARLEN, M1_ARLEN;
  logic [2:0]  M0_AWSIZE, M1_AWSIZE, M0_ARSIZE, M1_ARSIZE;
  logic [1:0]  M0_AWBURST, M1_AWBURST, M0_ARBURST, M1_ARBURST;
  logic        M0_AWVALID, M1_AWVALID, M0_ARVALID, M1_ARVALID;
  logic        M0_AWREADY, M1_AWREADY, M0_ARREADY, M1_ARREADY;
  logic [31:0] M0_WDATA, M1_WDATA, M0_RDATA, M1_RDATA;
  logic        M0_WLAST, M1_WLAST, M0_WVALID, M1_WVALID, M0_WREADY, M1_WREADY;
  logic        M0_RLAST, M1_RLAST, M0_RVALID, M1_RVALID, M0_RREADY, M1_RREADY;
  logic [31:0] S_AWADDR, S_ARADDR, S_WDATA, S_RDATA;
  logic [3:0]  S_AWLEN, S_ARLEN;
  logic [2:0]  S_AWSIZE, S_ARSIZE;
  logic [1:0]  S_AWBURST, S_ARBURST;
  logic        S_AWVALID, S_AWREADY, S_ARVALID, S_ARREADY;
  logic        S_WLAST, S_WVALID, S_WREADY, S_RLAST, S_RVALID, S_RREADY;
  logic [1:0]  WGRANT, RGRANT;
  logic        WLAST_ERR, RLAST_ERR;

  int n_pass  = 0;
  int n_total = 0;

  always #5 ACLK = ~ACLK;

  axi_rr_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_AWADDR(M0_AWADDR), .M0_AWLEN(M0_AWLEN), .M0_AWSIZE(M0_AWSIZE), .M0_AWBURST(M0_AWBURST),
    .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
    .M0_WDATA(M0_WDATA), .M0_WLAST(M0_WLAST), .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
    .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE), .M0_ARBURST(M0_ARBURST),
    .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RDATA(M0_RDATA), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_AWADDR(M1_AWADDR), .M1_AWLEN(M1_AWLEN), .M1_AWSIZE(M1_AWSIZE), .M1_AWBURST(M1_AWBURST),
    .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
    .M1_WDATA(M1_WDATA), .M1_WLAST(M1_WLAST), .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE), .M1_ARBURST(M1_ARBURST),
    .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RDATA(M1_RDATA), .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .WGRANT(WGRANT), .RGRANT(RGRANT), .WLAST_ERR(WLAST_ERR), .RLAST_ERR(RLAST_ERR)
  );

  // OR of every DUT output; must be 0 whenever reset is held or the arbiter is fully idle.
  wire any_out = |{M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY, M0_ARREADY, M1_ARREADY,
                   M0_RDATA, M0_RLAST, M0_RVALID, M1_RDATA, M1_RLAST, M1_RVALID,
                   S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
                   S_WDATA, S_WLAST, S_WVALID,
                   S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
                   WGRANT, RGRANT, WLAST_ERR, RLAST_ERR};

  task automatic nxt();
    @(posedge ACLK);
    #1;
  endtask

  task automatic smp();
    @(negedge ACLK);
  endtask

  task automatic drive_w(input logic [1:0] g, input logic v, input logic [31:0] d, input logic l);
    if (g[0]) begin M0_WVALID = v; M0_WDATA = d; M0_WLAST = l; end
    else      begin M1_WVALID = v; M1_WDATA = d; M1_WLAST = l; end
  endtask

  task automatic test_reset();
    M0_AWVALID = 1'b1; M1_ARVALID = 1'b1; M0_WVALID = 1'b1; M0_RREADY = 1'b1;
    S_RVALID = 1'b1; S_RDATA = 32'hDEAD_BEEF; S_RLAST = 1'b1;
    repeat (2) smp();
    n_total++; if (any_out !== 1'b0) $display("FAIL reset_outputs: got any_out=%b expected 0", any_out); else n_pass++;
    n_total++; if (WGRANT !== 2'b00) $display("FAIL reset_wgrant: got %b expected 00", WGRANT); else n_pass++;
    M0_AWVALID = 1'b0; M1_ARVALID = 1'b0; M0_WVALID = 1'b0; M0_RREADY = 1'b0;
    S_RVALID = 1'b0; S_RDATA = '0; S_RLAST = 1'b0;
    ARESET = 1'b0;
    nxt(); smp();
    n_total++; if (any_out !== 1'b0) $display("FAIL idle_outputs: got any_out=%b expected 0", any_out); else n_pass++;
  endtask

  task automatic test_write_rr();
    nxt();
    M0_AWADDR = 32'h100; M0_AWLEN = 4'd3; M0_AWSIZE = 3'd2; M0_AWBURST = 2'd1; M0_AWVALID = 1'b1;
    M1_AWADDR = 32'h200; M1_AWLEN = 4'd0; M1_AWVALID = 1'b1;
    smp();
    n_total++; if (WGRANT !== 2'b00) $display("FAIL rr_bubble_grant: got %b expected 00", WGRANT); else n_pass++;
    n_total++; if (S_AWVALID !== 1'b0) $display("FAIL rr_bubble_awvalid: got %b expected 0", S_AWVALID); else n_pass++;
    nxt(); smp();
    n_total++; if (WGRANT !== 2'b01) $display("FAIL rr_first_grant: got %b expected 01", WGRANT); else n_pass++;
    n_total++; if (S_AWADDR !== 32'h100) $display("FAIL rr_awaddr_m0: got %h expected 100", S_AWADDR); else n_pass++;
    n_total++; if (S_AWLEN !== 4'd3 || S_AWSIZE !== 3'd2 || S_AWBURST !== 2'd1)
      $display("FAIL rr_aw_payload: got len=%0d size=%0d burst=%0d expected 3 2 1", S_AWLEN, S_AWSIZE, S_AWBURST); else n_pass++;
    n_total++; if (M0_AWREADY !== 1'b1 || M1_AWREADY !== 1'b0)
      $display("FAIL rr_awready: got m0=%b m1=%b expected 1 0", M0_AWREADY, M1_AWREADY); else n_pass++;
    nxt();
    M0_AWVALID = 1'b0; M0_WVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      M0_WDATA = 32'hA0 + 32'(i); M0_WLAST = (i == 3);
      smp();
      n_total++; if (S_WDATA !== 32'hA0 + 32'(i)) $display("FAIL rr_wdata beat %0d: got %h expected %h", i, S_WDATA, 32'hA0 + 32'(i)); else n_pass++;
      n_total++; if (S_WLAST !== (i == 3)) $display("FAIL rr_wlast beat %0d: got %b expected %b", i, S_WLAST, (i == 3)); else n_pass++;
      n_total++; if (M0_WREADY !== 1'b1 || M1_WREADY !== 1'b0 || WGRANT !== 2'b01)
        $display("FAIL rr_wready beat %0d: got m0=%b m1=%b grant=%b expected 1 0 01", i, M0_WREADY, M1_WREADY, WGRANT); else n_pass++;
      nxt();
    end
    M0_WVALID = 1'b0; M0_WLAST = 1'b0;
    smp();
    n_total++; if (WGRANT !== 2'b00) $display("FAIL rr_end_grant: got %b expected 00", WGRANT); else n_pass++;
    nxt(); smp();
    n_total++; if (WGRANT !== 2'b10) $display("FAIL rr_second_grant: got %b expected 10", WGRANT); else n_pass++;
    n_total++; if (S_AWADDR !== 32'h200 || M1_AWREADY !== 1'b1 || M0_AWREADY !== 1'b0)
      $display("FAIL rr_m1_addr: got addr=%h m1rdy=%b m0rdy=%b expected 200 1 0", S_AWADDR, M1_AWREADY, M0_AWREADY); else n_pass++;
    nxt();
    M1_AWVALID = 1'b0; M1_WVALID = 1'b1; M1_WDATA = 32'hB0; M1_WLAST = 1'b1;
    smp();
    n_total++; if (S_WDATA !== 32'hB0 || S_WLAST !== 1'b1 || M1_WREADY !== 1'b1 || M0_WREADY !== 1'b0)
      $display("FAIL rr_m1_beat: got data=%h last=%b m1rdy=%b m0rdy=%b expected b0 1 1 0", S_WDATA, S_WLAST, M1_WREADY, M0_WREADY); else n_pass++;
    nxt();
    M1_WVALID = 1'b0; M1_WLAST = 1'b0;
    smp();
    n_total++; if (WGRANT !== 2'b00 || S_WVALID !== 1'b0) $display("FAIL rr_m1_done: got grant=%b wvalid=%b expected 00 0", WGRANT, S_WVALID); else n_pass++;
  endtask

  task automatic test_concurrent();
    nxt();
    M0_AWADDR = 32'h400; M0_AWLEN = 4'd7; M0_AWVALID = 1'b1;
    M1_ARADDR = 32'h300; M1_ARLEN = 4'd0; M1_ARVALID = 1'b1;
    smp();
    n_total++; if (WGRANT !== 2'b00 || RGRANT !== 2'b00) $display("FAIL cc_bubble: got w=%b r=%b expected 00 00", WGRANT, RGRANT); else n_pass++;
    nxt(); smp();
    n_total++; if (WGRANT !== 2'b01 || RGRANT !== 2'b10) $display("FAIL cc_grants: got w=%b r=%b expected 01 10", WGRANT, RGRANT); else n_pass++;
    n_total++; if (S_ARADDR !== 32'h300 || S_ARVALID !== 1'b1 || M1_ARREADY !== 1'b1 || M0_ARREADY !== 1'b0)
      $display("FAIL cc_ar: got addr=%h v=%b m1rdy=%b m0rdy=%b expected 300 1 1 0", S_ARADDR, S_ARVALID, M1_ARREADY, M0_ARREADY); else n_pass++;
    nxt();
    M0_AWVALID = 1'b0; M1_ARVALID = 1'b0; M0_WVALID = 1'b1;
    S_RVALID = 1'b1; S_RDATA = 32'hC0; S_RLAST = 1'b1; M1_RREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      M0_WDATA = 32'h40 + 32'(i); M0_WLAST = (i == 7);
      smp();
      if (i == 0) begin
        n_total++; if (M1_RVALID !== 1'b1 || M1_RDATA !== 32'hC0 || M0_RVALID !== 1'b0 || S_RREADY !== 1'b1 || RLAST_ERR !== 1'b0)
          $display("FAIL cc_rbeat: got m1v=%b m1d=%h m0v=%b rrdy=%b err=%b expected 1 c0 0 1 0", M1_RVALID, M1_RDATA, M0_RVALID, S_RREADY, RLAST_ERR); else n_pass++;
      end
      if (i == 1) begin
        n_total++; if (RGRANT !== 2'b00) $display("FAIL cc_read_done: got %b expected 00", RGRANT); else n_pass++;
      end
      n_total++; if (S_WLAST !== (i == 7) || WGRANT !== 2'b01 || WLAST_ERR !== 1'b0)
        $display("FAIL cc_wbeat %0d: got last=%b grant=%b err=%b expected %b 01 0", i, S_WLAST, WGRANT, WLAST_ERR, (i == 7)); else n_pass++;
      nxt();
      if (i == 0) begin S_RVALID = 1'b0; S_RLAST = 1'b0; S_RDATA = '0; M1_RREADY = 1'b0; end
    end
    M0_WVALID = 1'b0; M0_WLAST = 1'b0;
    smp();
    n_total++; if (WGRANT !== 2'b00) $display("FAIL cc_write_done: got %b expected 00", WGRANT); else n_pass++;
  endtask

  task automatic test_wlast_err();
    nxt();
    M0_AWADDR = 32'h500; M0_AWLEN = 4'd3; M0_AWVALID = 1'b1;
    smp(); nxt(); smp();
    n_total++; if (WGRANT !== 2'b01) $display("FAIL we_grant: got %b expected 01", WGRANT); else n_pass++;
    nxt();
    M0_AWVALID = 1'b0; M0_WVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      M0_WDATA = 32'h50 + 32'(i); M0_WLAST = (i == 1) || (i == 3);
      if (i == 2) begin
        S_WREADY = 1'b0;
        smp();
        n_total++; if (M0_WREADY !== 1'b0 || S_WVALID !== 1'b1 || WLAST_ERR !== 1'b0)
          $display("FAIL we_stall: got rdy=%b v=%b err=%b expected 0 1 0", M0_WREADY, S_WVALID, WLAST_ERR); else n_pass++;
        nxt();
        S_WREADY = 1'b1;
      end
      smp();
      n_total++; if (WLAST_ERR !== (i == 1)) $display("FAIL we_err beat %0d: got %b expected %b", i, WLAST_ERR, (i == 1)); else n_pass++;
      n_total++; if (S_WLAST !== (i == 3) || WGRANT !== 2'b01)
        $display("FAIL we_count beat %0d: got last=%b grant=%b expected %b 01", i, S_WLAST, WGRANT, (i == 3)); else n_pass++;
      nxt();
    end
    M0_WVALID = 1'b0; M0_WLAST = 1'b0;
    smp();
    n_total++; if (WGRANT !== 2'b00 || WLAST_ERR !== 1'b0) $display("FAIL we_done: got grant=%b err=%b expected 00 0", WGRANT, WLAST_ERR); else n_pass++;
  endtask

  task automatic test_rlast_err();
    nxt();
    M0_ARADDR = 32'h600; M0_ARLEN = 4'd2; M0_ARVALID = 1'b1; S_ARREADY = 1'b0;
    smp(); nxt(); smp();
    n_total++; if (RGRANT !== 2'b01 || M0_ARREADY !== 1'b0 || S_ARVALID !== 1'b1)
      $display("FAIL re_stall: got grant=%b rdy=%b v=%b expected 01 0 1", RGRANT, M0_ARREADY, S_ARVALID); else n_pass++;
    nxt();
    S_ARREADY = 1'b1;
    smp();
    n_total++; if (M0_ARREADY !== 1'b1) $display("FAIL re_arready: got %b expected 1", M0_ARREADY); else n_pass++;
    nxt();
    M0_ARVALID = 1'b0; S_RVALID = 1'b1; S_RLAST = 1'b0; M0_RREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      S_RDATA = 32'hD0 + 32'(i);
      smp();
      n_total++; if (M0_RDATA !== 32'hD0 + 32'(i) || M0_RVALID !== 1'b1 || M1_RVALID !== 1'b0 || RGRANT !== 2'b01)
        $display("FAIL re_beat %0d: got d=%h v0=%b v1=%b grant=%b expected %h 1 0 01", i, M0_RDATA, M0_RVALID, M1_RVALID, RGRANT, 32'hD0 + 32'(i)); else n_pass++;
      n_total++; if (RLAST_ERR !== (i == 2)) $display("FAIL re_err beat %0d: got %b expected %b", i, RLAST_ERR, (i == 2)); else n_pass++;
      nxt();
    end
    S_RVALID = 1'b0; S_RDATA = '0; M0_RREADY = 1'b0;
    smp();
    n_total++; if (RGRANT !== 2'b00 || RLAST_ERR !== 1'b0) $display("FAIL re_done: got grant=%b err=%b expected 00 0", RGRANT, RLAST_ERR); else n_pass++;
  endtask

  task automatic test_reset_mid();
    nxt();
    M0_AWADDR = 32'h700; M0_AWLEN = 4'd3; M0_AWVALID = 1'b1;
    smp(); nxt(); smp(); nxt();
    M0_AWVALID = 1'b0; M0_WVALID = 1'b1; M0_WDATA = 32'hE0;
    smp();
    n_total++; if (S_WDATA !== 32'hE0) $display("FAIL rm_beat1: got %h expected e0", S_WDATA); else n_pass++;
    nxt();
    M0_WDATA = 32'hE1;
    smp();
    n_total++; if (S_WVALID !== 1'b1) $display("FAIL rm_beat2_valid: got %b expected 1", S_WVALID); else n_pass++;
    #1 ARESET = 1'b1;
    #1;
    n_total++; if (any_out !== 1'b0) $display("FAIL rm_async_outputs: got any_out=%b expected 0", any_out); else n_pass++;
    M0_WVALID = 1'b0; M0_WDATA = '0;
    @(posedge ACLK);
    #2 ARESET = 1'b0;
    M1_AWADDR = 32'h800; M1_AWLEN = 4'd0; M1_AWVALID = 1'b1;
    smp();
    n_total++; if (WGRANT !== 2'b00) $display("FAIL rm_after_release: got %b expected 00", WGRANT); else n_pass++;
    nxt(); smp();
    n_total++; if (WGRANT !== 2'b10 || S_AWADDR !== 32'h800)
      $display("FAIL rm_m1_grant: got grant=%b addr=%h expected 10 800", WGRANT, S_AWADDR); else n_pass++;
    nxt();
    M1_AWVALID = 1'b0; M1_WVALID = 1'b1; M1_WDATA = 32'hF0; M1_WLAST = 1'b1;
    smp();
    n_total++; if (S_WLAST !== 1'b1 || S_WDATA !== 32'hF0) $display("FAIL rm_m1_beat: got last=%b data=%h expected 1 f0", S_WLAST, S_WDATA); else n_pass++;
    nxt();
    M1_WVALID = 1'b0; M1_WLAST = 1'b0;
    smp();
    n_total++; if (WGRANT !== 2'b00) $display("FAIL rm_done: got %b expected 00", WGRANT); else n_pass++;
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    nxt();
    M0_AWADDR = 32'h900; M0_AWLEN = 4'd1; M0_AWVALID = 1'b1;
    M1_AWADDR = 32'hA00; M1_AWLEN = 4'd1; M1_AWVALID = 1'b1;
    for (int b = 0; b < 3; b++) begin
      exp_g = (b == 1) ? 2'b10 : 2'b01;
      smp();
      n_total++; if (WGRANT !== 2'b00) $display("FAIL fair_bubble %0d: got %b expected 00", b, WGRANT); else n_pass++;
      nxt(); smp();
      n_total++; if (WGRANT !== exp_g) $display("FAIL fair_grant %0d: got %b expected %b", b, WGRANT, exp_g); else n_pass++;
      nxt();
      if (exp_g[1]) M1_AWVALID = 1'b0;
      for (int j = 0; j < 2; j++) begin
        drive_w(exp_g, 1'b1, 32'h90 + 32'(4 * b + j), (j == 1));
        smp();
        n_total++; if (S_WDATA !== 32'h90 + 32'(4 * b + j) || S_WLAST !== (j == 1))
          $display("FAIL fair_beat %0d.%0d: got data=%h last=%b expected %h %b", b, j, S_WDATA, S_WLAST, 32'h90 + 32'(4 * b + j), (j == 1)); else n_pass++;
        nxt();
      end
      drive_w(exp_g, 1'b0, '0, 1'b0);
    end
    M0_AWVALID = 1'b0;
    smp();
    n_total++; if (WGRANT !== 2'b00) $display("FAIL fair_done: got %b expected 00", WGRANT); else n_pass++;
  endtask

  initial begin
    ARESET = 1'b1;
    M0_AWADDR = '0; M0_AWLEN = '0; M0_AWSIZE = '0; M0_AWBURST = '0; M0_AWVALID = 1'b0;
    M1_AWADDR = '0; M1_AWLEN = '0; M1_AWSIZE = '0; M1_AWBURST = '0; M1_AWVALID = 1'b0;
    M0_ARADDR = '0; M0_ARLEN = '0; M0_ARSIZE = '0; M0_ARBURST = '0; M0_ARVALID = 1'b0;
    M1_ARADDR = '0; M1_ARLEN = '0; M1_ARSIZE = '0; M1_ARBURST = '0; M1_ARVALID = 1'b0;
    M0_WDATA = '0; M0_WLAST = 1'b0; M0_WVALID = 1'b0; M0_RREADY = 1'b0;
    M1_WDATA = '0; M1_WLAST = 1'b0; M1_WVALID = 1'b0; M1_RREADY = 1'b0;
    S_AWREADY = 1'b1; S_WREADY = 1'b1; S_ARREADY = 1'b1;
    S_RDATA = '0; S_RLAST = 1'b0; S_RVALID = 1'b0;
    test_reset();
    test_write_rr();
    test_concurrent();
    test_wlast_err();
    test_rlast_err();
    test_reset_mid();
    test_fairness();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
